// File: rtl/stream_rand_stall.sv
// Valid/ready gate that inserts a pseudo-random number of stall cycles ahead of each transfer.
// Optional stall-cycle statistics counter enabled by defining STREAM_RAND_STALL_STATS_EN.
module stream_rand_stall #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RndWidth  = 8,
  parameter int unsigned MaxStall  = 15,
  parameter int unsigned CntWidth  = (MaxStall > 0) ? $clog2(MaxStall + 1) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bypass_i,
  input  logic [RndWidth-1:0]  rnd_i,
  output logic                 rnd_req_o,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [31:0]          stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PASS
  } state_e;

  localparam logic [CntWidth-1:0] MaxStallC = CntWidth'(MaxStall);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Zero-extend before slicing so a narrow rnd_i never under-fills the counter.
  logic [RndWidth+CntWidth-1:0] rnd_ext;
  logic [CntWidth-1:0]          rnd_raw;
  logic [CntWidth-1:0]          stall;
  logic                         unused_rnd_bits;

  assign rnd_ext         = {{CntWidth{1'b0}}, rnd_i};
  assign rnd_raw         = rnd_ext[CntWidth-1:0];
  assign unused_rnd_bits = ^rnd_ext[RndWidth+CntWidth-1:CntWidth];
  assign stall           = (rnd_raw > MaxStallC) ? MaxStallC : rnd_raw;

  assign data_o = data_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_o   = 1'b0;
    ready_o   = 1'b0;
    rnd_req_o = 1'b0;

    if (bypass_i) begin
      valid_o = valid_i;
      ready_o = ready_i;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            rnd_req_o = 1'b1;
            if (stall == '0) begin
              state_d = PASS;
            end else begin
              cnt_d   = stall;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntWidth'(1)) begin
            state_d = PASS;
          end
        end
        PASS: begin
          valid_o = valid_i;
          ready_o = ready_i;
          if (valid_i && ready_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs stay quiet for the whole reset assertion, not just after the next edge.
    if (!rst_ni) begin
      valid_o   = 1'b0;
      ready_o   = 1'b0;
      rnd_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STREAM_RAND_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_i && !valid_o && !bypass_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
  logic                 hold_valid_q;
  logic                 hold_data_q;
  logic [DataWidth-1:0] data_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 1'b0;
      data_prev_q  <= '0;
    end else begin
      hold_valid_q <= (state_q != IDLE) && !bypass_i && valid_i && !ready_o;
      hold_data_q  <= valid_i && !ready_o;
      data_prev_q  <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && hold_valid_q) begin
      a_valid_held: assert (valid_i);
    end
    if (rst_ni && hold_data_q && valid_i) begin
      a_data_stable: assert (data_i == data_prev_q);
    end
  end
`endif

endmodule

// File: tb/tb_stream_rand_stall.sv
// Directed bench for stream_rand_stall: stall timing, clamp, backpressure, bypass, reset,
// MaxStall=0 and an LFSR-fed run of 100 transfers.
module tb_stream_rand_stall;

`ifdef STREAM_RAND_STALL_STATS_EN
  localparam int ExpStatsA = 6;
  localparam int ExpStatsB = 6;
`else
  localparam int ExpStatsA = 0;
  localparam int ExpStatsB = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        bypass_i;
  logic        ready_i;
  logic [7:0]  rnd_dir;
  logic [7:0]  rnd_i;
  logic [31:0] data_i;
  logic        use_lfsr;
  logic [15:0] lfsr_q;

  logic        valid_a, valid_b, valid_c;
  logic        rnd_req_a, rnd_req_b, rnd_req_c;
  logic        ready_o_a, ready_o_b, ready_o_c;
  logic        valid_o_a, valid_o_b, valid_o_c;
  logic [31:0] data_o_a, data_o_b, data_o_c;
  logic [31:0] stats_a, stats_b, stats_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_i = ~clk_i;

  // 16-bit Galois LFSR standing in for the upstream lfsr (OutWidth=8).
  assign rnd_i = use_lfsr ? lfsr_q[7:0] : rnd_dir;
  always @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else if (rnd_req_a) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  stream_rand_stall #(.DataWidth(32), .RndWidth(8), .MaxStall(15)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(bypass_i), .rnd_i(rnd_i), .rnd_req_o(rnd_req_a),
    .valid_i(valid_a), .ready_o(ready_o_a), .data_i(data_i), .valid_o(valid_o_a),
    .ready_i(ready_i), .data_o(data_o_a), .stall_cycles_o(stats_a)
  );

  stream_rand_stall #(.DataWidth(32), .RndWidth(8), .MaxStall(5)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(1'b0), .rnd_i(rnd_i), .rnd_req_o(rnd_req_b),
    .valid_i(valid_b), .ready_o(ready_o_b), .data_i(data_i), .valid_o(valid_o_b),
    .ready_i(ready_i), .data_o(data_o_b), .stall_cycles_o(stats_b)
  );

  stream_rand_stall #(.DataWidth(32), .RndWidth(8), .MaxStall(0)) dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(1'b0), .rnd_i(rnd_i), .rnd_req_o(rnd_req_c),
    .valid_i(valid_c), .ready_o(ready_o_c), .data_i(data_i), .valid_o(valid_o_c),
    .ready_i(ready_i), .data_o(data_o_c), .stall_cycles_o(stats_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    int idle_cycles;
    int exp_stall;
    int budget;
    bit done;

    rst_ni   = 1'b0;
    bypass_i = 1'b0;
    ready_i  = 1'b1;
    rnd_dir  = 8'h00;
    data_i   = 32'h1234_5678;
    valid_a  = 1'b1;
    valid_b  = 1'b0;
    valid_c  = 1'b0;
    use_lfsr = 1'b0;

    // Reset state, with valid_i already high.
    repeat (2) @(posedge clk_i);
    #2;
    check_eq("rst_valid_o", 32'(valid_o_a), 0);
    check_eq("rst_ready_o", 32'(ready_o_a), 0);
    check_eq("rst_rnd_req", 32'(rnd_req_a), 0);
    check_eq("rst_stats",   stats_a, 0);
    check_eq("rst_data_o",  data_o_a, 32'h1234_5678);
    check_eq("rst_cnt",     32'(dut_a.cnt_q), 0);
    tick(); rst_ni = 1'b1; valid_a = 1'b0; #1;

    // Zero stall: sample at t, valid_o at t+1, back in IDLE at t+2.
    tick(); valid_a = 1'b1; data_i = 32'h1111_1111; rnd_dir = 8'h00; ready_i = 1'b1; #1;
    check_eq("z_t_req",    32'(rnd_req_a), 1);
    check_eq("z_t_valid",  32'(valid_o_a), 0);
    tick(); #1;
    check_eq("z_t1_valid", 32'(valid_o_a), 1);
    check_eq("z_t1_ready", 32'(ready_o_a), 1);
    check_eq("z_t1_req",   32'(rnd_req_a), 0);
    check_eq("z_t1_data",  data_o_a, 32'h1111_1111);
    tick(); data_i = 32'h2222_2222; #1;
    check_eq("z_t2_req",   32'(rnd_req_a), 1);
    check_eq("z_t2_valid", 32'(valid_o_a), 0);
    tick(); #1;
    check_eq("z_t3_valid", 32'(valid_o_a), 1);
    tick(); valid_a = 1'b0; #1;

    // Clamp on MaxStall=5: rnd 0x0F -> raw 7 -> stall 5.
    tick(); valid_b = 1'b1; data_i = 32'h5555_5555; rnd_dir = 8'h0F; #1;
    check_eq("c_req",     32'(rnd_req_b), 1);
    check_eq("c_valid_t", 32'(valid_o_b), 0);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      check_eq("c_wait", 32'(valid_o_b), 0);
      if (k == 1) check_eq("c_cnt", 32'(dut_b.cnt_q), 5);
    end
    tick(); #1;
    check_eq("c_rise",  32'(valid_o_b), 1);
    check_eq("c_ready", 32'(ready_o_b), 1);
    tick(); valid_b = 1'b0; #1;
    check_eq("c_stats", stats_b, ExpStatsB);

    // Backpressure in PASS with stall 3.
    pulses = 0;
    tick(); valid_a = 1'b1; data_i = 32'hDEAD_BEEF; rnd_dir = 8'h03; ready_i = 1'b0; #1;
    if (rnd_req_a) pulses++;
    check_eq("bp_req", 32'(rnd_req_a), 1);
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      if (rnd_req_a) pulses++;
      check_eq("bp_wait", 32'(valid_o_a), 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      if (rnd_req_a) pulses++;
      check_eq("bp_valid", 32'(valid_o_a), 1);
      check_eq("bp_ready", 32'(ready_o_a), 0);
      check_eq("bp_data",  data_o_a, 32'hDEAD_BEEF);
    end
    tick(); ready_i = 1'b1; #1;
    if (rnd_req_a) pulses++;
    check_eq("bp_hs_valid", 32'(valid_o_a), 1);
    check_eq("bp_hs_ready", 32'(ready_o_a), 1);
    tick(); valid_a = 1'b0; #1;
    if (rnd_req_a) pulses++;
    check_eq("bp_pulses", pulses, 1);
    check_eq("bp_stats",  stats_a, ExpStatsA);

    // Bypass asserted in the middle of a 10-cycle WAIT.
    tick(); valid_a = 1'b1; data_i = 32'hA5A5_A5A5; rnd_dir = 8'h0A; ready_i = 1'b1; #1;
    check_eq("bw_req", 32'(rnd_req_a), 1);
    tick(); #1;
    check_eq("bw_wait1", 32'(valid_o_a), 0);
    tick(); #1;
    check_eq("bw_wait2", 32'(valid_o_a), 0);
    tick(); bypass_i = 1'b1; #1;
    check_eq("bw_byp_valid", 32'(valid_o_a), 1);
    check_eq("bw_byp_ready", 32'(ready_o_a), 1);
    check_eq("bw_byp_req",   32'(rnd_req_a), 0);
    tick(); data_i = 32'h5A5A_5A5A; ready_i = 1'b0; #1;
    check_eq("bw_cnt",        32'(dut_a.cnt_q), 0);
    check_eq("bw_byp_req2",   32'(rnd_req_a), 0);
    check_eq("bw_byp_valid2", 32'(valid_o_a), 1);
    check_eq("bw_byp_ready2", 32'(ready_o_a), 0);
    tick(); bypass_i = 1'b0; rnd_dir = 8'h00; #1;
    check_eq("bw_fresh_req",   32'(rnd_req_a), 1);
    check_eq("bw_fresh_valid", 32'(valid_o_a), 0);
    tick(); ready_i = 1'b1; #1;
    check_eq("bw_pass", 32'(valid_o_a), 1);
    tick(); valid_a = 1'b0; #1;

    // Reset in the middle of a 7-cycle WAIT, then a fresh sample.
    tick(); valid_a = 1'b1; data_i = 32'h7777_7777; rnd_dir = 8'h07; #1;
    check_eq("rw_req", 32'(rnd_req_a), 1);
    tick(); #1;
    check_eq("rw_wait", 32'(valid_o_a), 0);
    tick(); rst_ni = 1'b0; #1;
    check_eq("rw_rst_valid", 32'(valid_o_a), 0);
    check_eq("rw_rst_req",   32'(rnd_req_a), 0);
    check_eq("rw_rst_ready", 32'(ready_o_a), 0);
    tick(); #1;
    check_eq("rw_rst_cnt", 32'(dut_a.cnt_q), 0);
    tick(); rst_ni = 1'b1; rnd_dir = 8'h01; #1;
    check_eq("rw_resample_req", 32'(rnd_req_a), 1);
    check_eq("rw_rel_valid",    32'(valid_o_a), 0);
    tick(); #1;
    check_eq("rw_wait2", 32'(valid_o_a), 0);
    tick(); #1;
    check_eq("rw_pass", 32'(valid_o_a), 1);
    tick(); valid_a = 1'b0; #1;

    // MaxStall=0: raw 1 clamps to 0, so IDLE then PASS.
    tick(); valid_c = 1'b1; data_i = 32'hC0C0_C0C0; rnd_dir = 8'hFF; #1;
    check_eq("m0_req",   32'(rnd_req_c), 1);
    check_eq("m0_valid", 32'(valid_o_c), 0);
    tick(); #1;
    check_eq("m0_pass", 32'(valid_o_c), 1);
    tick(); valid_c = 1'b0; #1;

    // LFSR-fed run: stall must equal the low nibble of the sampled word.
    use_lfsr = 1'b1;
    pulses   = 0;
    for (int n = 0; n < 100; n++) begin
      tick(); valid_a = 1'b1; data_i = 32'hC000_0000 + n;
      done        = 1'b0;
      idle_cycles = 0;
      exp_stall   = 0;
      budget      = 0;
      while (!done) begin
        ready_i = 1'($urandom_range(0, 1));
        #1;
        if (rnd_req_a) begin
          pulses++;
          exp_stall = int'(rnd_i[3:0]);
        end
        if (!valid_o_a) begin
          idle_cycles++;
        end else if (ready_o_a) begin
          check_eq("lf_stall", 32'(idle_cycles - 1), exp_stall);
          check_eq("lf_bound", 32'(idle_cycles - 1 <= 15), 1);
          check_eq("lf_data",  data_o_a, 32'hC000_0000 + n);
          done = 1'b1;
        end
        if (!done) begin
          budget++;
          if (budget > 60) begin
            check_eq("lf_timeout", budget, 0);
            done = 1'b1;
          end else begin
            tick();
          end
        end
      end
    end
    tick(); valid_a = 1'b0; ready_i = 1'b1; #1;
    check_eq("lf_pulses", pulses, 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
